// File: rtl/tcore_param.sv
// rtl/tcore_param.sv - shared core parameters, dcache lower-side types and bridge state enum
package tcore_param;

  localparam int XLEN     = 32;
  localparam int BLK_SIZE = 128;

  typedef enum logic [1:0] {
    NO_SIZE   = 2'd0,
    BYTE      = 2'd1,
    HALF_WORD = 2'd2,
    WORD      = 2'd3
  } rw_size_e;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic                uncached;
    logic [XLEN-1:0]     addr;
    logic                rw;
    rw_size_e            rw_size;
    logic [BLK_SIZE-1:0] data;
  } dlowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } dlowX_res_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } dbridge_state_e;

endpackage

// File: rtl/dlowx_mem_bridge.sv
// rtl/dlowx_mem_bridge.sv - splits dcache line requests into 32-bit memory beats
module dlowx_mem_bridge
  import tcore_param::*;
#(
  parameter int BLK_SIZE = tcore_param::BLK_SIZE,
  parameter int XLEN     = tcore_param::XLEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  dlowX_req_t       lowX_req_i,
  output dlowX_res_t       lowX_res_o,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_wstrb_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i
);

  localparam int NUM_BEATS = BLK_SIZE / 32;
  localparam int BOFFSET   = $clog2(BLK_SIZE / 8);
  localparam int BW        = BOFFSET - 2;

  dbridge_state_e      state_q;
  logic [BW-1:0]       beat_q;
  logic [BLK_SIZE-1:0] line_q;
  logic                uncached_q;
  logic [XLEN-1:0]     addr_q;
  logic                rw_q;
  rw_size_e            size_q;
  logic [BLK_SIZE-1:0] data_q;
  logic                req_valid_q;
  logic                res_valid_q;
  logic                res_ready_q;

  logic [BW-1:0]       word_idx;
  logic                last_beat;
  logic                unused_req_ready;

  assign unused_req_ready = lowX_req_i.ready;

  // Uncached accesses touch only the lane selected by the address; cached ones walk the line.
  assign word_idx  = uncached_q ? addr_q[BOFFSET-1:2] : beat_q;
  assign last_beat = uncached_q || (beat_q == BW'(NUM_BEATS - 1));

  assign mem_req_valid_o = req_valid_q;
  assign mem_we_o        = rw_q;
  assign mem_addr_o      = uncached_q ? {addr_q[XLEN-1:2], 2'b00}
                                      : {addr_q[XLEN-1:BOFFSET], beat_q, 2'b00};
  assign mem_wdata_o     = rw_q ? data_q[{word_idx, 5'b0} +: 32] : 32'h0;

  always_comb begin
    mem_wstrb_o = 4'h0;
    if (rw_q) begin
      if (!uncached_q) begin
        mem_wstrb_o = 4'hF;
      end else begin
        case (size_q)
          BYTE:      mem_wstrb_o = 4'b0001 << addr_q[1:0];
          HALF_WORD: mem_wstrb_o = 4'b0011 << addr_q[1];
          default:   mem_wstrb_o = 4'hF;
        endcase
      end
    end
  end

  always_comb begin
    lowX_res_o       = '0;
    lowX_res_o.valid = res_valid_q;
    lowX_res_o.ready = res_ready_q;
    lowX_res_o.data  = line_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      line_q      <= '0;
      uncached_q  <= 1'b0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      size_q      <= NO_SIZE;
      data_q      <= '0;
      req_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (lowX_req_i.valid && res_ready_q) begin
            uncached_q  <= lowX_req_i.uncached;
            addr_q      <= lowX_req_i.addr;
            rw_q        <= lowX_req_i.rw;
            size_q      <= lowX_req_i.rw_size;
            data_q      <= lowX_req_i.data;
            line_q      <= '0;
            beat_q      <= '0;
            req_valid_q <= 1'b1;
            res_ready_q <= 1'b0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            if (!rw_q) begin
              req_valid_q <= 1'b0;
              state_q     <= WAIT_R;
            end else if (last_beat) begin
              req_valid_q <= 1'b0;
              res_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        WAIT_R: begin
          if (mem_rvalid_i) begin
            line_q[{word_idx, 5'b0} +: 32] <= mem_rdata_i;
            if (last_beat) begin
              res_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              beat_q      <= beat_q + 1'b1;
              req_valid_q <= 1'b1;
              state_q     <= REQ;
            end
          end
        end
        RESP: begin
          res_valid_q <= 1'b0;
          res_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dlowx_mem_bridge.md
DLOWX_MEM_BRIDGE -- requirements
Module: dlowx_mem_bridge

Interface
REQ-001 SHALL have parameter BLK_SIZE, default tcore_param::BLK_SIZE, meaning cache line width in bits (multiple of 32).
REQ-002 SHALL have parameter XLEN, default tcore_param::XLEN, meaning address width.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock.
REQ-004 SHALL have port rst_i, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port lowX_req_i, input, dlowX_req_t, meaning the dcache lower-side request (valid, ready, uncached, addr, rw, rw_size, data).
REQ-006 SHALL have port lowX_res_o, output, dlowX_res_t, meaning the response to the dcache (valid, ready, data).
REQ-007 SHALL have port mem_req_valid_o, output, 1, meaning a word beat request is valid.
REQ-008 SHALL have port mem_req_ready_i, input, 1, meaning memory accepts the beat.
REQ-009 SHALL have port mem_addr_o, output, XLEN, meaning word-aligned beat address.
REQ-010 SHALL have port mem_we_o, output, 1, meaning the beat is a write.
REQ-011 SHALL have port mem_wstrb_o, output, 4, meaning write byte strobes.
REQ-012 SHALL have port mem_wdata_o, output, 32, meaning write data.
REQ-013 SHALL have port mem_rvalid_i, input, 1, meaning read data is valid, in order, at most one outstanding.
REQ-014 SHALL have port mem_rdata_i, input, 32, meaning read data.

Function
REQ-015 SHALL use NUM_BEATS = BLK_SIZE/32 and BOFFSET = log2(BLK_SIZE/8).
REQ-016 SHALL implement states IDLE, REQ, WAIT_R, RESP.
REQ-017 SHALL drive lowX_res_o.ready=1 only in IDLE and accept when lowX_req_i.valid && ready; it SHALL latch addr, rw, uncached, rw_size and data, then go to REQ.
REQ-018 Cached request (uncached=0) SHALL run NUM_BEATS beats at addr[XLEN-1:BOFFSET] concatenated with beat*4; beat counter 0..NUM_BEATS-1 with no wrap.
REQ-019 Uncached request SHALL run exactly one beat at {addr[XLEN-1:2],2'b00}; lane index L = addr[BOFFSET-1:2].
REQ-020 In REQ, SHALL hold mem_req_valid_o=1 with stable address, we, wstrb and wdata until mem_req_ready_i.
REQ-021 A write beat SHALL complete on handshake; wdata = line word [beat*32+:32] if cached, line word L if uncached.
REQ-022 wstrb SHALL be 4'hF for cached and WORD/NO_SIZE; 4'b0011<<addr[1] for HALF_WORD; 4'b0001<<addr[1:0] for BYTE; 0 for reads.
REQ-023 A read beat SHALL move REQ->WAIT_R on handshake and store mem_rdata_i into the line buffer word [beat*32+:32] (uncached: word L) when mem_rvalid_i=1; mem_rvalid_i seen in the handshake cycle itself is ignored.
REQ-024 After the last beat completes, SHALL go to RESP, assert lowX_res_o.valid for exactly one cycle with data = line buffer (all zeros for writes), then return to IDLE.
REQ-025 SHALL keep ready=0 in RESP; the earliest next accept is the cycle after RESP.
REQ-026 Minimum latency with zero-wait memory and rvalid one cycle after handshake: cached read 2*NUM_BEATS+2 cycles from accept to valid; cached write NUM_BEATS+2 cycles.
REQ-027 SHALL clear the line buffer at accept so unwritten uncached lanes read 0.
REQ-028 SHALL ignore lowX_req_i changes while not in IDLE.

Reset
REQ-029 On rst_i=1, asynchronously: state=IDLE, beat=0, line buffer=0, latched request=0, mem_req_valid_o=0, lowX_res_o.valid=0, data=0.
REQ-030 lowX_res_o.ready SHALL be 1 after reset; reset mid-transfer SHALL abort with no response and no further mem beats.

Structure
REQ-031 The state enum (dbridge_state_e) SHALL live in tcore_param; dlowX_req_t/dlowX_res_t SHALL be reused unchanged.
REQ-032 SHALL be a single module with no sub-modules; strobe and lane logic inline.

Verification (BLK_SIZE=128)
REQ-033 Cached read addr 0x1000_0040, memory returns 0x11,0x22,0x33,0x44 -> beats to 0x40,0x44,0x48,0x4C; one valid pulse, data=0x00000044_00000033_00000022_00000011.
REQ-034 Writeback rw=1 addr 0x2000_0020, data words A0..A3 -> four writes, wstrb=F, wdata A0..A3 in order; valid pulse with data 0.
REQ-035 Uncached BYTE write addr 0x3000_0006, lane 1 = 0xAB -> single beat addr 0x3000_0004, wstrb=4'b0100, wdata=0xAB.
REQ-036 mem_req_ready_i low 5 cycles on beat 2 -> address/wdata stable, no extra beats, response 5 cycles later.
REQ-037 Assert rst_i during beat 1 of a read -> next cycle mem_req_valid_o=0, ready=1, no lowX_res_o.valid pulse.
REQ-038 lowX_req_i.valid held high through RESP -> no re-accept in RESP; new accept the following IDLE cycle.
